// File: rtl/alu4_exec_ctrl.sv
// alu4_exec_ctrl: issue/writeback controller wrapped around a combinational alu4.
// Accepts one instruction per handshake, snapshots operands from a 4x4-bit
// register file into the alu4 input registers, waits EXEC_WAIT settle cycles,
// then writes the alu4 result back and latches the flags.
module alu4_exec_ctrl #(
  parameter int unsigned EXEC_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       instr_ld,
  input  logic [2:0] instr_op,
  input  logic [1:0] instr_rd,
  input  logic [1:0] instr_rs,
  input  logic [1:0] instr_rt,
  input  logic       instr_imm_en,
  input  logic [3:0] instr_imm,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_c,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_v,
  output logic       flag_c,
  output logic       flag_n,
  output logic       flag_z,
  output logic       flag_v,
  output logic       busy,
  output logic       done,
  input  logic [1:0] rd_sel,
  output logic [3:0] rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] regs_q [4];
  logic [3:0] regs_d [4];
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic [1:0] rd_q, rd_d;          // destination captured at accept
  logic [3:0] flags_q, flags_d;    // {c, n, z, v}
  logic [2:0] cnt_q, cnt_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Next-state, datapath and registered-output decode for the issue/exec/done sequence.
  always_comb begin
    state_d  = state_q;
    regs_d   = regs_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    rd_d     = rd_q;
    flags_d  = flags_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          if (instr_ld) begin
            // Loads bypass the ALU and leave the flags alone.
            regs_d[instr_rd] = instr_imm;
            state_d          = ST_DONE;
          end else begin
            // Operands are snapshotted here so rd may alias rs/rt safely.
            alu_a_d  = regs_q[instr_rs];
            alu_b_d  = instr_imm_en ? instr_imm : regs_q[instr_rt];
            alu_op_d = instr_op;
            rd_d     = instr_rd;
            cnt_d    = 3'(EXEC_WAIT);
            state_d  = ST_EXEC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          regs_d[rd_q] = alu_result;
          flags_d      = {alu_c, alu_n, alu_z, alu_v};
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State, register file and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      regs_q   <= '{default: 4'd0};
      alu_a_q  <= 4'd0;
      alu_b_q  <= 4'd0;
      alu_op_q <= 3'd0;
      rd_q     <= 2'd0;
      flags_q  <= 4'd0;
      cnt_q    <= 3'd0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      regs_q   <= regs_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      rd_q     <= rd_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign flag_c      = flags_q[3];
  assign flag_n      = flags_q[2];
  assign flag_z      = flags_q[1];
  assign flag_v      = flags_q[0];
  // Debug read port is combinational so a writeback is visible right after its edge.
  assign rd_data     = regs_q[rd_sel];

endmodule

// File: tb/tb_alu4_exec_ctrl.sv
// Self-checking bench for alu4_exec_ctrl. Three instances (EXEC_WAIT 0, 2, 3)
// each get their own alu4 model; a scoreboard holds expected writebacks.
module tb_alu4_exec_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  logic [2:0]      rst_n, valid, ready, ld, imm_en, busy, done;
  logic [2:0]      flag_c, flag_n, flag_z, flag_v;
  logic [2:0][2:0] op, alu_op;
  logic [2:0][1:0] rd, rs, rt, rd_sel;
  logic [2:0][3:0] imm, alu_a, alu_b, rd_data;

  // Reference alu4: returns {c, n, z, v, result}
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] o);
    logic [4:0] s;
    logic [3:0] r;
    logic       c, v;
    c = 1'b0; v = 1'b0; s = 5'd0;
    case (o)
      3'd0: r = ~a;
      3'd1: r = ~b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~(a ^ b);
      3'd6: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
      default: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
    endcase
    return {c, r[3], (r == 4'd0), v, r};
  endfunction

  function automatic int unsigned wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    logic [7:0] alu_out;
    assign alu_out = alu_f(alu_a[g], alu_b[g], alu_op[g]);
    alu4_exec_ctrl #(.EXEC_WAIT(W)) u_dut (
      .clk(clk), .reset_n(rst_n[g]),
      .instr_valid(valid[g]), .instr_ready(ready[g]), .instr_ld(ld[g]), .instr_op(op[g]),
      .instr_rd(rd[g]), .instr_rs(rs[g]), .instr_rt(rt[g]),
      .instr_imm_en(imm_en[g]), .instr_imm(imm[g]),
      .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_op(alu_op[g]),
      .alu_result(alu_out[3:0]), .alu_c(alu_out[7]), .alu_n(alu_out[6]), .alu_z(alu_out[5]), .alu_v(alu_out[4]),
      .flag_c(flag_c[g]), .flag_n(flag_n[g]), .flag_z(flag_z[g]), .flag_v(flag_v[g]),
      .busy(busy[g]), .done(done[g]), .rd_sel(rd_sel[g]), .rd_data(rd_data[g])
    );
  end

  typedef struct {
    int          k;
    logic        ld;
    logic [1:0]  rd;
    logic [3:0]  val;
    logic [3:0]  flg;
    int unsigned t_done;
  } sb_t;

  sb_t        sbq[$];
  logic [3:0] mreg [3][4];
  logic [3:0] mflag [3];

  task automatic drive(input int k, input logic l, input logic [2:0] o, input logic [1:0] d,
                       input logic [1:0] s, input logic [1:0] t, input logic ie, input logic [3:0] im);
    ld[k] = l; op[k] = o; rd[k] = d; rs[k] = s; rt[k] = t; imm_en[k] = ie; imm[k] = im;
  endtask

  // Called at the negedge right after the accept edge: update the model and queue the expectation.
  task automatic push_expect(input int k, input logic l, input logic [2:0] o, input logic [1:0] d,
                             input logic [1:0] s, input logic [1:0] t, input logic ie, input logic [3:0] im);
    sb_t        e;
    logic [7:0] r;
    e.k = k; e.ld = l; e.rd = d;
    if (l) begin
      mreg[k][d] = im;
      e.t_done   = cyc;
    end else begin
      r          = alu_f(mreg[k][s], ie ? im : mreg[k][t], o);
      mreg[k][d] = r[3:0];
      mflag[k]   = r[7:4];
      e.t_done   = cyc + 1 + wait_of(k);
    end
    e.val = mreg[k][d];
    e.flg = mflag[k];
    sbq.push_back(e);
  endtask

  task automatic issue(input int k, input logic l, input logic [2:0] o, input logic [1:0] d,
                       input logic [1:0] s, input logic [1:0] t, input logic ie, input logic [3:0] im);
    int n;
    n = 0;
    @(negedge clk);
    while (ready[k] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (ready[k] !== 1'b1) begin fails++; $display("FAIL issue_ready k=%0d got=%b want=1", k, ready[k]); end
    drive(k, l, o, d, s, t, ie, im);
    valid[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[k] = 1'b0;
    push_expect(k, l, o, d, s, t, ie, im);
  endtask

  // Pop one expectation and compare it against the next done pulse.
  task automatic wait_done();
    sb_t e;
    int  n;
    n = 0;
    checks++;
    if (sbq.size() == 0) begin fails++; $display("FAIL sb_empty got=0 want>0"); return; end
    e = sbq.pop_front();
    rd_sel[e.k] = e.rd;
    while (done[e.k] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (done[e.k] !== 1'b1) begin fails++; $display("FAIL done_timeout k=%0d got=%b want=1", e.k, done[e.k]); end
    checks++;
    if (cyc !== e.t_done) begin fails++; $display("FAIL done_latency k=%0d got=%0d want=%0d", e.k, cyc, e.t_done); end
    checks++;
    if ({ready[e.k], busy[e.k]} !== 2'b01) begin fails++; $display("FAIL done_status k=%0d got=%b want=01", e.k, {ready[e.k], busy[e.k]}); end
    #1;
    checks++;
    if (rd_data[e.k] !== e.val) begin fails++; $display("FAIL writeback k=%0d r%0d got=%h want=%h", e.k, e.rd, rd_data[e.k], e.val); end
    checks++;
    if ({flag_c[e.k], flag_n[e.k], flag_z[e.k], flag_v[e.k]} !== e.flg) begin
      fails++; $display("FAIL flags k=%0d got=%b want=%b", e.k, {flag_c[e.k], flag_n[e.k], flag_z[e.k], flag_v[e.k]}, e.flg);
    end
    @(negedge clk);
    checks++;
    if ({done[e.k], ready[e.k], busy[e.k]} !== 3'b010) begin
      fails++; $display("FAIL done_pulse k=%0d got=%b want=010", e.k, {done[e.k], ready[e.k], busy[e.k]});
    end
  endtask

  task automatic test_reset();
    rst_n = 3'b000; valid = 3'b000; ld = 3'b000; op = '0; rd = '0; rs = '0; rt = '0;
    imm_en = 3'b000; imm = '0; rd_sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 3'b111;
    for (int k = 0; k < 3; k++) begin
      mflag[k] = 4'd0;
      for (int r = 0; r < 4; r++) mreg[k][r] = 4'd0;
      checks++;
      if ({ready[k], busy[k], done[k]} !== 3'b100) begin fails++; $display("FAIL reset_status k=%0d got=%b want=100", k, {ready[k], busy[k], done[k]}); end
      checks++;
      if ({alu_a[k], alu_b[k], alu_op[k], flag_c[k], flag_n[k], flag_z[k], flag_v[k]} !== 15'd0) begin
        fails++; $display("FAIL reset_alu_flags k=%0d got=%h want=0", k, {alu_a[k], alu_b[k], alu_op[k], flag_c[k], flag_n[k], flag_z[k], flag_v[k]});
      end
      for (int r = 0; r < 4; r++) begin
        rd_sel[k] = 2'(r);
        #1;
        checks++;
        if (rd_data[k] !== 4'd0) begin fails++; $display("FAIL reset_reg k=%0d r%0d got=%h want=0", k, r, rd_data[k]); end
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    issue(2, 1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 4'd5); wait_done();
    issue(2, 1'b0, 3'd6, 2'd2, 2'd1, 2'd1, 1'b0, 4'd0);
    void'(sbq.pop_back());
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b1;
    mflag[2] = 4'd0;
    for (int r = 0; r < 4; r++) mreg[2][r] = 4'd0;
    checks++;
    if ({ready[2], busy[2]} !== 2'b10) begin fails++; $display("FAIL abort_status got=%b want=10", {ready[2], busy[2]}); end
    for (int n = 0; n < 6; n++) begin
      rd_sel[2] = 2'd2;
      #1;
      checks++;
      if ({done[2], rd_data[2], flag_c[2], flag_n[2], flag_z[2], flag_v[2]} !== 9'd0) begin
        fails++; $display("FAIL abort_writeback got=%h want=0", {done[2], rd_data[2], flag_c[2], flag_n[2], flag_z[2], flag_v[2]});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_add_flags();
    issue(0, 1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd7); wait_done();
    issue(0, 1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 4'd7); wait_done();
    issue(0, 1'b0, 3'd6, 2'd2, 2'd0, 2'd1, 1'b0, 4'd0); wait_done();
    rd_sel[0] = 2'd2;
    #1;
    checks++;
    if ({rd_data[0], flag_c[0], flag_n[0], flag_z[0], flag_v[0]} !== {4'hE, 4'b0101}) begin
      fails++; $display("FAIL add_7_7 got=%h want=%h", {rd_data[0], flag_c[0], flag_n[0], flag_z[0], flag_v[0]}, {4'hE, 4'b0101});
    end
  endtask

  task automatic test_snapshot();
    issue(0, 1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 1'b0, 4'hA); wait_done();
    issue(0, 1'b0, 3'd7, 2'd3, 2'd3, 2'd3, 1'b0, 4'd0); wait_done();
    rd_sel[0] = 2'd3;
    #1;
    checks++;
    if ({rd_data[0], flag_c[0], flag_n[0], flag_z[0], flag_v[0]} !== {4'h0, 4'b1010}) begin
      fails++; $display("FAIL sub_self got=%h want=%h", {rd_data[0], flag_c[0], flag_n[0], flag_z[0], flag_v[0]}, {4'h0, 4'b1010});
    end
  endtask

  task automatic test_imm();
    issue(0, 1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'hF); wait_done();
    issue(0, 1'b0, 3'd6, 2'd1, 2'd0, 2'd2, 1'b1, 4'hF); wait_done();
    rd_sel[0] = 2'd1;
    #1;
    checks++;
    if ({rd_data[0], flag_c[0], flag_n[0], flag_z[0], flag_v[0]} !== {4'hE, 4'b1100}) begin
      fails++; $display("FAIL add_imm got=%h want=%h", {rd_data[0], flag_c[0], flag_n[0], flag_z[0], flag_v[0]}, {4'hE, 4'b1100});
    end
    issue(0, 1'b0, 3'd4, 2'd2, 2'd0, 2'd1, 1'b1, 4'h5); wait_done();
    rd_sel[0] = 2'd2;
    #1;
    checks++;
    if ({rd_data[0], flag_c[0], flag_n[0], flag_z[0], flag_v[0]} !== {4'hA, 4'b0100}) begin
      fails++; $display("FAIL xor_imm got=%h want=%h", {rd_data[0], flag_c[0], flag_n[0], flag_z[0], flag_v[0]}, {4'hA, 4'b0100});
    end
  endtask

  task automatic test_all_ops();
    for (int o = 0; o < 8; o++) begin
      for (int rep = 0; rep < 2; rep++) begin
        issue(1, 1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'($urandom)); wait_done();
        issue(1, 1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 4'($urandom)); wait_done();
        issue(1, 1'b0, 3'(o), 2'(o % 4), 2'd0, 2'd1, 1'(rep), 4'($urandom)); wait_done();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  t_op [3];
    logic [1:0]  t_rd [3];
    logic [1:0]  t_rs [3];
    logic [1:0]  t_rt [3];
    int unsigned acc [3];
    logic        prev_ready;
    int          i, ndone, n;
    sb_t         e;
    t_op = '{3'd6, 3'd7, 3'd4};
    t_rd = '{2'd3, 2'd0, 2'd1};
    t_rs = '{2'd2, 2'd3, 2'd0};
    t_rt = '{2'd1, 2'd2, 2'd3};
    acc  = '{0, 0, 0};
    i = 0; ndone = 0; n = 0;
    @(negedge clk);
    prev_ready = ready[0];
    drive(0, 1'b0, t_op[0], t_rd[0], t_rs[0], t_rt[0], 1'b0, 4'd0);
    valid[0] = 1'b1;
    while ((i < 3 || ndone < 3) && n < 60) begin
      @(negedge clk);
      n++;
      if (valid[0] && prev_ready) begin
        push_expect(0, 1'b0, t_op[i], t_rd[i], t_rs[i], t_rt[i], 1'b0, 4'd0);
        acc[i] = cyc;
        i++;
        if (i < 3) drive(0, 1'b0, t_op[i], t_rd[i], t_rs[i], t_rt[i], 1'b0, 4'd0);
        else valid[0] = 1'b0;
      end
      if (done[0] === 1'b1 && sbq.size() > 0) begin
        e = sbq.pop_front();
        rd_sel[0] = e.rd;
        #1;
        checks++;
        if (rd_data[0] !== e.val || {flag_c[0], flag_n[0], flag_z[0], flag_v[0]} !== e.flg || cyc !== e.t_done) begin
          fails++; $display("FAIL b2b_result r%0d got=%h/%b@%0d want=%h/%b@%0d", e.rd, rd_data[0],
                            {flag_c[0], flag_n[0], flag_z[0], flag_v[0]}, cyc, e.val, e.flg, e.t_done);
        end
        ndone++;
      end
      prev_ready = ready[0];
    end
    valid[0] = 1'b0;
    checks++;
    if (i != 3 || ndone != 3 || sbq.size() != 0) begin fails++; $display("FAIL b2b_count got=%0d/%0d want=3/3", i, ndone); end
    checks++;
    if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
      fails++; $display("FAIL b2b_spacing got=%0d,%0d want=3,3", acc[1] - acc[0], acc[2] - acc[1]);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin fails++; $display("FAIL b2b_extra got=%b want=00", {done[0], busy[0]}); end
    end
  endtask

  task automatic test_busy_change();
    sb_t e;
    int  n;
    issue(1, 1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd3); wait_done();
    issue(1, 1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 4'd9); wait_done();
    issue(1, 1'b0, 3'd7, 2'd2, 2'd0, 2'd1, 1'b0, 4'd0);
    e = sbq.pop_front();
    valid[1] = 1'b1;
    n = 0;
    while (done[1] !== 1'b1 && n < 20) begin
      checks++;
      if ({alu_a[1], alu_b[1], alu_op[1]} !== {4'd3, 4'd9, 3'd7}) begin
        fails++; $display("FAIL busy_alu_stable got=%h want=%h", {alu_a[1], alu_b[1], alu_op[1]}, {4'd3, 4'd9, 3'd7});
      end
      drive(1, 1'($urandom), 3'($urandom), 2'd0, 2'($urandom), 2'($urandom), 1'($urandom), 4'($urandom));
      @(negedge clk);
      n++;
    end
    valid[1] = 1'b0;
    rd_sel[1] = 2'd2;
    #1;
    checks++;
    if (cyc !== e.t_done || rd_data[1] !== e.val || {flag_c[1], flag_n[1], flag_z[1], flag_v[1]} !== e.flg) begin
      fails++; $display("FAIL busy_writeback got=%h/%b@%0d want=%h/%b@%0d", rd_data[1],
                        {flag_c[1], flag_n[1], flag_z[1], flag_v[1]}, cyc, e.val, e.flg, e.t_done);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rd_sel[1] = 2'd0;
      #1;
      checks++;
      if ({busy[1], rd_data[1]} !== {1'b0, mreg[1][0]}) begin
        fails++; $display("FAIL busy_ignored got=%h want=%h", {busy[1], rd_data[1]}, {1'b0, mreg[1][0]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_exec();
    test_add_flags();
    test_snapshot();
    test_imm();
    test_all_ops();
    test_back_to_back();
    test_busy_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
